// File: rtl/sd_pkg.sv
// sd_pkg: shared types and defaults for the "1011" scanning arbiter.
package sd_pkg;
    localparam int SD_W = 8;
    localparam int SD_CNT_W = 4;
    typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, RESULT} state_t;
    typedef enum logic [2:0] {D_0, D_1, D_10, D_101, D_1011} det_t;
    // After a full match the recogniser overlaps from "1" or "10".
    function automatic det_t det_next(input det_t s, input logic b);
        case (s)
            D_0:     det_next = b ? D_1 : D_0;
            D_1:     det_next = b ? D_1 : D_10;
            D_10:    det_next = b ? D_101 : D_0;
            D_101:   det_next = b ? D_1011 : D_10;
            D_1011:  det_next = b ? D_1 : D_10;
            default: det_next = D_0;
        endcase
    endfunction
endpackage

// File: rtl/sd_match_core.sv
// sd_match_core: Moore overlapping "1011" recogniser; match is high the cycle after the 4th bit.
module sd_match_core import sd_pkg::*; (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic bit_in,
    output logic match
);
    det_t st;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) st <= D_0;
        else       st <= clear ? D_0 : det_next(st, bit_in);
    end
    assign match = st == D_1011;
endmodule

// File: rtl/sd_scan_arb.sv
// sd_scan_arb: round-robin arbiter for two word requesters; counts "1011" matches per word, MSB first.
module sd_scan_arb import sd_pkg::*; #(
    parameter int W = SD_W,
    parameter int CNT_W = SD_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [W-1:0]     req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [W-1:0]     req1_data,
    output logic             req1_ready,
    output logic             res_valid,
    output logic             res_id,
    output logic [CNT_W-1:0] res_count,
    input  logic             res_ready,
    output logic             busy
);
    localparam int BW = $clog2(W);
    state_t state, next;
    logic last, armed, grant, take, match;
    logic [W-1:0] sreg;
    logic [BW-1:0] cnt;
    logic [CNT_W-1:0] count;
    logic id;

    sd_match_core u_core (
        .clock (clock),
        .reset (reset),
        .clear (take),
        .bit_in(sreg[W-1]),
        .match (match)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    // armed keeps both readys low for the first cycle out of reset.
    always_comb begin
        next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        take = 1'b0;
        grant = (req0_valid && req1_valid) ? ~last : req1_valid;
        case (state)
            IDLE: if (armed && (req0_valid || req1_valid)) begin
                req0_ready = ~grant;
                req1_ready = grant;
                take = 1'b1;
                next = SHIFT;
            end
            SHIFT:  next = (cnt == BW'(W - 1)) ? DRAIN : SHIFT;
            DRAIN:  next = RESULT;
            RESULT: next = res_ready ? IDLE : RESULT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last <= 1'b1;
            armed <= 1'b0;
            sreg <= '0;
            cnt <= '0;
            count <= '0;
            id <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (take) begin
                sreg <= grant ? req1_data : req0_data;
                cnt <= '0;
                count <= '0;
                id <= grant;
                last <= grant;
            end else if (state == SHIFT) begin
                sreg <= {sreg[W-2:0], 1'b0};
                cnt <= cnt + 1'b1;
            end
            if ((state == SHIFT || state == DRAIN) && match && count != {CNT_W{1'b1}})
                count <= count + 1'b1;
        end
    end

    assign res_valid = state == RESULT;
    assign busy = state != IDLE;
    assign res_id = id;
    assign res_count = count;
endmodule

// File: tb/tb_sd_scan_arb.sv
// tb_sd_scan_arb: directed vectors with hand-computed counts, grants and latencies.
module tb_sd_scan_arb;
    localparam int W = 8;
    localparam int CNT_W = 4;
    logic clock = 1'b0, reset = 1'b1;
    logic req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b0;
    logic [W-1:0] req0_data = '0, req1_data = '0;
    logic req0_ready, req1_ready, res_valid, res_id, busy;
    logic [CNT_W-1:0] res_count;
    int n_chk = 0, n_err = 0;

    sd_scan_arb #(.W(W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_id(res_id), .res_count(res_count),
        .res_ready(res_ready), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the requester's valid already driven.
    task automatic run(input string tag, input logic id, input logic keep, input logic early,
                       input int hold, input logic [3:0] exp);
        int k;
        k = 0;
        #1;
        while (!(id ? req1_ready : req0_ready) && k < 20) begin
            @(negedge clock);
            #1;
            k++;
        end
        chk({tag, "_rdy"}, {req1_ready, req0_ready}, id ? 2'b10 : 2'b01);
        @(negedge clock);
        if (!keep) begin
            if (id) req1_valid = 1'b0;
            else req0_valid = 1'b0;
        end
        if (early) res_ready = 1'b1;
        chk({tag, "_busy"}, {busy, req1_ready, req0_ready, res_valid}, 4'b1000);
        repeat (W) @(negedge clock);
        chk({tag, "_drain"}, res_valid, 1'b0);
        @(negedge clock);
        chk({tag, "_res"}, {res_valid, res_id, res_count}, {1'b1, id, exp});
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk({tag, "_hold"}, {res_valid, res_id, res_count, busy, req1_ready, req0_ready},
                {1'b1, id, exp, 3'b100});
        end
        res_ready = 1'b1;
        @(negedge clock);
        res_ready = 1'b0;
        chk({tag, "_idle"}, {res_valid, busy}, 2'b00);
    endtask

    initial begin
        req0_valid = 1'b1;
        req0_data = 8'b10110110;
        repeat (2) @(negedge clock);
        #1 chk("rst_hold", {res_valid, res_id, res_count, busy, req1_ready, req0_ready}, 9'd0);
        @(negedge clock);
        reset = 1'b0;
        #1 chk("rst_rel", {res_valid, res_id, res_count, busy, req1_ready, req0_ready}, 9'd0);
        @(negedge clock);
        run("single", 1'b0, 1'b0, 1'b0, 0, 4'd2);
        req0_data = 8'b00000101; req0_valid = 1'b1;
        run("xw_a", 1'b0, 1'b0, 1'b0, 0, 4'd0);
        req0_data = 8'b10000000; req0_valid = 1'b1;
        run("xw_b", 1'b0, 1'b0, 1'b1, 0, 4'd0);
        req1_data = 8'b10111011; req1_valid = 1'b1;
        run("ovl", 1'b1, 1'b0, 1'b0, 0, 4'd2);
        req1_data = 8'b00000000; req1_valid = 1'b1;
        run("zero", 1'b1, 1'b0, 1'b0, 0, 4'd0);
        req0_data = 8'b10110110; req0_valid = 1'b1;
        req1_data = 8'b00001011; req1_valid = 1'b1;
        run("rr0", 1'b0, 1'b1, 1'b0, 0, 4'd2);
        run("rr1", 1'b1, 1'b1, 1'b0, 0, 4'd1);
        run("rr2", 1'b0, 1'b1, 1'b0, 0, 4'd2);
        run("rr3", 1'b1, 1'b1, 1'b0, 0, 4'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clock);
        req0_data = 8'b11011011; req0_valid = 1'b1;
        req1_data = 8'b00101101; req1_valid = 1'b1;
        run("bp", 1'b0, 1'b0, 1'b0, 5, 4'd2);
        run("bp1", 1'b1, 1'b0, 1'b0, 0, 4'd1);
        @(negedge clock);
        req0_data = 8'b10110110; req0_valid = 1'b1;
        #1 chk("mid_rdy", {req1_ready, req0_ready}, 2'b01);
        @(negedge clock);
        req0_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        req0_data = 8'b00001011; req0_valid = 1'b1;
        req1_data = 8'b11111111; req1_valid = 1'b1;
        #1 chk("mid_rst", {res_valid, res_id, res_count, busy, req1_ready, req0_ready}, 9'd0);
        @(negedge clock);
        reset = 1'b0;
        #1 chk("mid_rel", {res_valid, res_id, res_count, busy, req1_ready, req0_ready}, 9'd0);
        @(negedge clock);
        run("post0", 1'b0, 1'b0, 1'b0, 0, 4'd1);
        run("post1", 1'b1, 1'b0, 1'b0, 0, 4'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
